mem_port_arbiter: RTL and testbench

Arbitrates the data port of the dual-port instruction/data BRAM between the CPU MEM stage and a debug/DMA requester. It multiplexes address, write data, size and sign onto the BRAM data port and stalls the CPU whenever the debug side owns the port. Read responses are routed back to the requester that issued them. A starvation counter guarantees the debug port a slot under continuous CPU traffic.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 82 ++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the BRAM data-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, debug and BRAM data-port signals shared between the arbiter and its neighbours.
interface mem_port_arbiter_if;

  logic        CPU_REQ;
  logic        CPU_WE;
  logic [31:0] CPU_ADDR;
  logic [31:0] CPU_DIN;
  logic [1:0]  CPU_SIZE;
  logic        CPU_SIGN;
  logic        CPU_STALL;
  logic        CPU_RVALID;
  logic [31:0] CPU_DOUT;

  logic        DBG_VALID;
  logic        DBG_READY;
  logic        DBG_WE;
  logic [31:0] DBG_ADDR;
  logic [31:0] DBG_DIN;
  logic [1:0]  DBG_SIZE;
  logic        DBG_SIGN;
  logic        DBG_RVALID;
  logic [31:0] DBG_RDATA;

  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic        MEM_READ2;
  logic        MEM_WRITE2;
  logic [31:0] MEM_DOUT2;

  // Arbiter view.
  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, CPU_SIZE, CPU_SIGN,
    output CPU_STALL, CPU_RVALID, CPU_DOUT,
    input  DBG_VALID, DBG_WE, DBG_ADDR, DBG_DIN, DBG_SIZE, DBG_SIGN,
    output DBG_READY, DBG_RVALID, DBG_RDATA,
    output MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN, MEM_READ2, MEM_WRITE2,
    input  MEM_DOUT2
  );

  // Requester and BRAM view.
  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, CPU_SIZE, CPU_SIGN,
    input  CPU_STALL, CPU_RVALID, CPU_DOUT,
    output DBG_VALID, DBG_WE, DBG_ADDR, DBG_DIN, DBG_SIZE, DBG_SIGN,
    input  DBG_READY, DBG_RVALID, DBG_RDATA,
    input  MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN, MEM_READ2, MEM_WRITE2,
    output MEM_DOUT2
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// BRAM data-port arbiter: CPU has priority, debug is forced in after STARVE_MAX
// consecutive CPU grants; read data is steered back to whoever issued the load.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input logic                CLK,
  input logic                RST_N,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STARVE_MAX);

  logic             dbg_win;
  logic             cpu_win;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  owner_t           rd_owner_q, rd_owner_d;

  // Grant is gated by reset so nothing reaches the BRAM while RST_N is low.
  always_comb begin
    dbg_win = RST_N && bus.DBG_VALID && (!bus.CPU_REQ || (starve_cnt_q == CntMax));
    cpu_win = RST_N && bus.CPU_REQ && !dbg_win;
  end

  assign bus.DBG_READY = dbg_win;
  assign bus.CPU_STALL = bus.CPU_REQ && dbg_win;

  always_comb begin
    if (dbg_win) begin
      bus.MEM_ADDR2 = bus.DBG_ADDR;
      bus.MEM_DIN2  = bus.DBG_DIN;
      bus.MEM_SIZE  = bus.DBG_SIZE;
      bus.MEM_SIGN  = bus.DBG_SIGN;
    end else begin
      bus.MEM_ADDR2 = bus.CPU_ADDR;
      bus.MEM_DIN2  = bus.CPU_DIN;
      bus.MEM_SIZE  = bus.CPU_SIZE;
      bus.MEM_SIGN  = bus.CPU_SIGN;
    end
  end

  always_comb begin
    bus.MEM_WRITE2 = (cpu_win && bus.CPU_WE) || (dbg_win && bus.DBG_WE);
    bus.MEM_READ2  = (cpu_win && !bus.CPU_WE) || (dbg_win && !bus.DBG_WE);
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (cpu_win && bus.DBG_VALID) begin
      starve_cnt_d = (starve_cnt_q == CntMax) ? CntMax : starve_cnt_q + CNT_W'(1);
    end else if (dbg_win || !bus.DBG_VALID) begin
      starve_cnt_d = '0;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_win && !bus.CPU_WE) begin
      rd_owner_d = OWN_CPU;
    end else if (dbg_win && !bus.DBG_WE) begin
      rd_owner_d = OWN_DBG;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      starve_cnt_q <= '0;
      rd_owner_q   <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign bus.CPU_RVALID = (rd_owner_q == OWN_CPU);
  assign bus.DBG_RVALID = (rd_owner_q == OWN_DBG);
  assign bus.CPU_DOUT   = bus.MEM_DOUT2;
  assign bus.DBG_RDATA  = bus.MEM_DOUT2;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-addressable BRAM model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic CLK;
  logic RST_N;
  logic preload;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_MAX(8)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // BRAM model: synchronous read, write committed at the edge.
  logic [31:0] mem [0:1023];

  function automatic logic [31:0] ld(input logic [31:0] w, input logic [1:0] off,
                                     input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    logic [31:0] r;
    s = w >> {off, 3'b000};
    case (sz)
      SZ_BYTE: r = uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
      SZ_HALF: r = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] st(input logic [31:0] w, input logic [31:0] d,
                                     input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    case (sz)
      SZ_BYTE: r[off*8 +: 8] = d[7:0];
      SZ_HALF: r[off[1]*16 +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge CLK) begin
    if (preload) begin
      mem[10'h040] <= 32'hDEADBEEF;
      mem[10'h080] <= 32'h0;
      mem[10'h0C0] <= 32'h11223344;
      mem[10'h0C1] <= 32'h55667788;
    end else if (bus.MEM_WRITE2) begin
      mem[bus.MEM_ADDR2[11:2]] <= st(mem[bus.MEM_ADDR2[11:2]], bus.MEM_DIN2,
                                     bus.MEM_ADDR2[1:0], bus.MEM_SIZE);
    end
    if (bus.MEM_READ2) begin
      bus.MEM_DOUT2 <= ld(mem[bus.MEM_ADDR2[11:2]], bus.MEM_ADDR2[1:0], bus.MEM_SIZE,
                          bus.MEM_SIGN);
    end
  end

  typedef struct packed {
    logic        rst_n;
    logic        creq;
    logic        cwe;
    logic [31:0] caddr;
    logic [31:0] cdin;
    logic [1:0]  csz;
    logic        csign;
    logic        dv;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] ddin;
    logic [1:0]  dsz;
    logic        dsign;
    logic        e_stall;
    logic        e_ready;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [1:0]  e_size;
    logic        e_sign;
    logic        e_cv;
    logic        e_dv;
    logic [31:0] e_rdata;
  } vec_t;

  int n_pass;
  int n_total;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    RST_N         = v.rst_n;
    bus.CPU_REQ   = v.creq;
    bus.CPU_WE    = v.cwe;
    bus.CPU_ADDR  = v.caddr;
    bus.CPU_DIN   = v.cdin;
    bus.CPU_SIZE  = v.csz;
    bus.CPU_SIGN  = v.csign;
    bus.DBG_VALID = v.dv;
    bus.DBG_WE    = v.dwe;
    bus.DBG_ADDR  = v.daddr;
    bus.DBG_DIN   = v.ddin;
    bus.DBG_SIZE  = v.dsz;
    bus.DBG_SIGN  = v.dsign;
  endtask

  // Both requesters asking for a word load: CPU from 0x100, debug from 0x300.
  task automatic drive_both(input logic rst);
    vec_t v;
    v = '0;
    v.rst_n = rst;
    v.creq = 1'b1; v.caddr = 32'h100; v.csz = SZ_WORD;
    v.dv = 1'b1;   v.daddr = 32'h300; v.dsz = SZ_WORD;
    drive(v);
  endtask

  function automatic vec_t mk(
    input logic rst, input logic creq, input logic cwe, input logic [31:0] caddr,
    input logic [31:0] cdin, input logic [1:0] csz, input logic csign,
    input logic dv, input logic dwe, input logic [31:0] daddr, input logic [31:0] ddin,
    input logic [1:0] dsz, input logic dsign,
    input logic es, input logic er, input logic erd, input logic ewr,
    input logic [31:0] ea, input logic [1:0] esz, input logic esg,
    input logic ecv, input logic edv, input logic [31:0] ed);
    vec_t v;
    v.rst_n = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cdin = cdin;
    v.csz = csz; v.csign = csign; v.dv = dv; v.dwe = dwe; v.daddr = daddr;
    v.ddin = ddin; v.dsz = dsz; v.dsign = dsign; v.e_stall = es; v.e_ready = er;
    v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea; v.e_size = esz; v.e_sign = esg;
    v.e_cv = ecv; v.e_dv = edv; v.e_rdata = ed;
    return v;
  endfunction

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    n_pass  = 0;
    n_total = 0;
    preload = 1'b1;

    //            rst creq we addr          din        sz sg  dv we addr        din        sz sg
    //            stall rdy rd wr addr         sz sg  cv dv rdata
    vecs[0]  = mk(0, 1,0,32'h100,     32'h0,     2,0, 1,0,32'h300,32'h0,     2,0,
                  0,0,0,0, 32'h100,     2,0, 0,0,32'h0);
    vecs[1]  = vecs[0];
    vecs[2]  = mk(1, 1,0,32'h100,     32'h0,     2,0, 0,0,32'h0,  32'h0,     2,0,
                  0,0,1,0, 32'h100,     2,0, 0,0,32'h0);
    vecs[3]  = mk(1, 0,0,32'h0,       32'h0,     2,0, 0,0,32'h0,  32'h0,     2,0,
                  0,0,0,0, 32'h0,       2,0, 1,0,32'hDEADBEEF);
    vecs[4]  = mk(1, 0,0,32'h0,       32'h0,     2,0, 1,1,32'h200,32'hA5A5A5A5,2,0,
                  0,1,0,1, 32'h200,     2,0, 0,0,32'h0);
    vecs[5]  = mk(1, 1,0,32'h200,     32'h0,     2,0, 0,0,32'h0,  32'h0,     2,0,
                  0,0,1,0, 32'h200,     2,0, 0,0,32'h0);
    vecs[6]  = mk(1, 0,0,32'h0,       32'h0,     2,0, 0,0,32'h0,  32'h0,     2,0,
                  0,0,0,0, 32'h0,       2,0, 1,0,32'hA5A5A5A5);
    vecs[7]  = mk(1, 0,0,32'h0,       32'h0,     2,0, 1,0,32'h300,32'h0,     2,0,
                  0,1,1,0, 32'h300,     2,0, 0,0,32'h0);
    vecs[8]  = mk(1, 1,0,32'h304,     32'h0,     2,0, 0,0,32'h0,  32'h0,     2,0,
                  0,0,1,0, 32'h304,     2,0, 0,1,32'h11223344);
    vecs[9]  = mk(1, 0,0,32'h0,       32'h0,     2,0, 0,0,32'h0,  32'h0,     2,0,
                  0,0,0,0, 32'h0,       2,0, 1,0,32'h55667788);
    vecs[10] = mk(1, 0,0,32'h0,       32'h0,     2,0, 1,0,32'h103,32'h0,     0,1,
                  0,1,1,0, 32'h103,     0,1, 0,0,32'h0);
    vecs[11] = mk(1, 0,0,32'h0,       32'h0,     2,0, 0,0,32'h0,  32'h0,     2,0,
                  0,0,0,0, 32'h0,       2,0, 0,1,32'h000000DE);
    vecs[12] = mk(1, 1,1,32'h11000004,32'h1234,  1,0, 0,0,32'h0,  32'h0,     2,0,
                  0,0,0,1, 32'h11000004,1,0, 0,0,32'h0);
    vecs[13] = mk(1, 1,0,32'h100,     32'h0,     2,0, 1,0,32'h300,32'h0,     2,0,
                  0,0,1,0, 32'h100,     2,0, 0,0,32'h0);
    vecs[14] = mk(1, 0,0,32'h0,       32'h0,     2,0, 1,0,32'h300,32'h0,     2,0,
                  0,1,1,0, 32'h300,     2,0, 1,0,32'hDEADBEEF);
    vecs[15] = mk(1, 0,0,32'h0,       32'h0,     2,0, 0,0,32'h0,  32'h0,     2,0,
                  0,0,0,0, 32'h0,       2,0, 0,1,32'h11223344);

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      preload = (i < 2);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d stall", i), {31'b0, bus.CPU_STALL}, {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d ready", i), {31'b0, bus.DBG_READY}, {31'b0, vecs[i].e_ready});
      chk($sformatf("v%0d read2", i), {31'b0, bus.MEM_READ2}, {31'b0, vecs[i].e_rd});
      chk($sformatf("v%0d write2", i), {31'b0, bus.MEM_WRITE2}, {31'b0, vecs[i].e_wr});
      chk($sformatf("v%0d addr2", i), bus.MEM_ADDR2, vecs[i].e_addr);
      chk($sformatf("v%0d size", i), {30'b0, bus.MEM_SIZE}, {30'b0, vecs[i].e_size});
      chk($sformatf("v%0d sign", i), {31'b0, bus.MEM_SIGN}, {31'b0, vecs[i].e_sign});
      chk($sformatf("v%0d cpu_rvalid", i), {31'b0, bus.CPU_RVALID}, {31'b0, vecs[i].e_cv});
      chk($sformatf("v%0d dbg_rvalid", i), {31'b0, bus.DBG_RVALID}, {31'b0, vecs[i].e_dv});
      if (vecs[i].e_cv) chk($sformatf("v%0d cpu_dout", i), bus.CPU_DOUT, vecs[i].e_rdata);
      if (vecs[i].e_dv) chk($sformatf("v%0d dbg_rdata", i), bus.DBG_RDATA, vecs[i].e_rdata);
    end

    // Continuous CPU loads with debug pending: debug forced in every 9th cycle.
    for (int k = 0; k < 18; k++) begin
      logic exp_win;
      logic prev_win;
      @(negedge CLK);
      drive_both(1'b1);
      #1;
      exp_win  = (k == 8) || (k == 17);
      prev_win = (k == 9);
      chk($sformatf("starve%0d ready", k), {31'b0, bus.DBG_READY}, {31'b0, exp_win});
      chk($sformatf("starve%0d stall", k), {31'b0, bus.CPU_STALL}, {31'b0, exp_win});
      chk($sformatf("starve%0d addr2", k), bus.MEM_ADDR2, exp_win ? 32'h300 : 32'h100);
      chk($sformatf("starve%0d cpu_rvalid", k), {31'b0, bus.CPU_RVALID},
          {31'b0, (k != 0) && !prev_win});
      chk($sformatf("starve%0d dbg_rvalid", k), {31'b0, bus.DBG_RVALID}, {31'b0, prev_win});
    end

    // Build the counter up, then reset during a granted CPU load.
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      drive_both(1'b1);
      #1;
      chk($sformatf("pre_rst%0d read2", k), {31'b0, bus.MEM_READ2}, 32'h1);
    end
    #2 RST_N = 1'b0;
    @(negedge CLK);
    drive_both(1'b0);
    #1;
    chk("rst cpu_rvalid", {31'b0, bus.CPU_RVALID}, 32'h0);
    chk("rst dbg_rvalid", {31'b0, bus.DBG_RVALID}, 32'h0);
    chk("rst read2", {31'b0, bus.MEM_READ2}, 32'h0);
    chk("rst write2", {31'b0, bus.MEM_WRITE2}, 32'h0);
    chk("rst ready", {31'b0, bus.DBG_READY}, 32'h0);
    chk("rst stall", {31'b0, bus.CPU_STALL}, 32'h0);
    chk("rst addr2", bus.MEM_ADDR2, 32'h100);

    // Counter restarts from zero after reset: debug wins only on the 9th cycle.
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      drive_both(1'b1);
      #1;
      chk($sformatf("post_rst%0d ready", k), {31'b0, bus.DBG_READY}, {31'b0, k == 8});
      if (k == 0) chk("post_rst cpu_rvalid", {31'b0, bus.CPU_RVALID}, 32'h0);
    end

    @(negedge CLK);
    drive('0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
